uart_bus_bridge: RTL and testbench

Parametrised data-bus slave that maps the UART TX/RX FIFOs and a small control/status register set into the fwrisc data address space. It sits between the core's dvalid/dready data bus and the FIFO ports of the UART. Unlike the single-register glue it supersedes, it has:
- a transaction state machine;
- a bounded stall on TX-full;
- blocking or non-blocking RX reads;
- sticky overflow/underflow status;
- a maskable interrupt output.

---
 rtl/uart_bus_bridge.sv | 185 ++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_bridge.sv
// Data-bus slave mapping UART TX/RX FIFOs plus STATUS/CTRL registers into a
// 16-byte window, with bounded TX stall, optional blocking RX and a maskable IRQ.
module uart_bus_bridge #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           daddr_i,
  input  logic [31:0]           dwdata_i,
  input  logic [3:0]            dstrb_i,
  input  logic                  dwrite_i,
  input  logic                  dvalid_i,
  output logic [31:0]           drdata_o,
  output logic                  dready_o,
  output logic                  tx_fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0] tx_fifo_wdata_o,
  input  logic                  tx_fifo_full_i,
  output logic                  rx_fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] rx_fifo_rdata_i,
  input  logic                  rx_fifo_empty_i,
  output logic                  irq_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_WAIT,
    S_RX_WAIT,
    S_RX_DATA,
    S_DONE
  } state_e;

  localparam logic [3:0]  OFF_TX     = 4'h0;
  localparam logic [3:0]  OFF_RX     = 4'h4;
  localparam logic [3:0]  OFF_STATUS = 4'h8;
  localparam logic [3:0]  OFF_CTRL   = 4'hC;
  localparam bit          LIMITED    = (WAIT_LIMIT != 0);
  localparam logic [16:0] LIMIT      = 17'(WAIT_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        rx_unf_q, rx_unf_d;
  logic [15:0] cnt_q, cnt_d;
  logic        irq_q, irq_d;

  logic        in_window;
  logic [3:0]  offset;
  logic        ready, push, pop;
  logic        ovf_set, unf_set;
  logic [1:0]  w1c;
  logic [31:0] rdata, rx_word, status_word;
  logic        unused_bits;

  assign in_window   = (daddr_i[31:4] == BASE_ADDR[31:4]);
  assign offset      = daddr_i[3:0];
  assign unused_bits = ^{dstrb_i[3:1], dwdata_i};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    cnt_d       = cnt_q;
    ready       = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    rdata       = '0;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    w1c         = 2'b00;
    rx_word     = '0;
    rx_word[DATA_WIDTH-1:0] = rx_fifo_rdata_i;
    status_word = {28'd0, rx_unf_q, tx_ovf_q, rx_fifo_empty_i, tx_fifo_full_i};

    unique case (state_q)
      S_IDLE: begin
        if (dvalid_i && in_window) begin
          ready   = 1'b1;
          state_d = S_DONE;
          case (offset)
            OFF_TX: begin
              if (dwrite_i && dstrb_i[0]) begin
                if (!tx_fifo_full_i) begin
                  push = 1'b1;
                end else begin
                  ready   = 1'b0;
                  cnt_d   = '0;
                  state_d = S_TX_WAIT;
                end
              end
            end
            OFF_RX: begin
              if (!dwrite_i) begin
                if (!rx_fifo_empty_i) begin
                  pop     = 1'b1;
                  ready   = 1'b0;
                  state_d = S_RX_DATA;
                end else if (ctrl_q[0]) begin
                  ready   = 1'b0;
                  state_d = S_RX_WAIT;
                end else begin
                  unf_set = 1'b1;
                end
              end
            end
            OFF_STATUS: begin
              if (!dwrite_i)       rdata = status_word;
              else if (dstrb_i[0]) w1c   = dwdata_i[3:2];
            end
            OFF_CTRL: begin
              if (!dwrite_i)       rdata  = {28'd0, ctrl_q};
              else if (dstrb_i[0]) ctrl_d = dwdata_i[3:0];
            end
            default: ;
          endcase
        end
      end
      S_TX_WAIT: begin
        if (!tx_fifo_full_i) begin
          push    = 1'b1;
          ready   = 1'b1;
          state_d = S_DONE;
        end else if (LIMITED && ({1'b0, cnt_q} + 17'd1 >= LIMIT)) begin
          // The count includes the current cycle, so latency never exceeds the limit.
          ready   = 1'b1;
          ovf_set = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RX_WAIT: begin
        if (!rx_fifo_empty_i) begin
          pop     = 1'b1;
          state_d = S_RX_DATA;
        end
      end
      S_RX_DATA: begin
        ready   = 1'b1;
        rdata   = rx_word;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    tx_ovf_d = (tx_ovf_q & ~w1c[0]) | ovf_set;
    rx_unf_d = (rx_unf_q & ~w1c[1]) | unf_set;
    irq_d    = (ctrl_d[1] & ~tx_fifo_full_i) |
               (ctrl_d[2] & ~rx_fifo_empty_i) |
               (ctrl_d[3] & (tx_ovf_d | rx_unf_d));
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
      cnt_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
      cnt_q    <= cnt_d;
      irq_q    <= irq_d;
    end
  end

  // Combinational strobes are suppressed during reset so an aborted transfer
  // never completes or touches the FIFOs.
  assign dready_o        = ready & ~reset;
  assign tx_fifo_wr_en_o = push & ~reset;
  assign rx_fifo_rd_en_o = pop & ~reset;
  assign drdata_o        = (ready && !reset) ? rdata : '0;
  assign tx_fifo_wdata_o = reset ? '0 : dwdata_i[DATA_WIDTH-1:0];
  assign irq_o           = irq_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: table of bus transactions with a
// scoreboard of expected results, plus hand-written IRQ and reset sequences.
module tb_uart_bus_bridge;

  localparam logic [31:0] B   = 32'h8000_0000;
  localparam int          BIG = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dstrb;
  logic        dwrite, dvalid, dready;
  logic        tx_wr_en, tx_full, rx_rd_en, rx_empty, irq;
  logic [7:0]  tx_wdata;
  logic [7:0]  rx_rdata = 8'h00;
  logic [7:0]  cur_rx_byte = 8'h00;
  logic        idle_full = 1'b0;
  logic        idle_empty = 1'b1;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        wr;
    int          full_cyc;
    int          empty_cyc;
    logic [7:0]  rx_byte;
    logic        exp_ack;
    int          exp_lat;
    int          exp_push;
    int          exp_pop;
    int          exp_strobe_cyc;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];

  uart_bus_bridge #(
    .DATA_WIDTH(8),
    .BASE_ADDR (32'h8000_0000),
    .WAIT_LIMIT(16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .daddr_i        (daddr),
    .dwdata_i       (dwdata),
    .dstrb_i        (dstrb),
    .dwrite_i       (dwrite),
    .dvalid_i       (dvalid),
    .drdata_o       (drdata),
    .dready_o       (dready),
    .tx_fifo_wr_en_o(tx_wr_en),
    .tx_fifo_wdata_o(tx_wdata),
    .tx_fifo_full_i (tx_full),
    .rx_fifo_rd_en_o(rx_rd_en),
    .rx_fifo_rdata_i(rx_rdata),
    .rx_fifo_empty_i(rx_empty),
    .irq_o          (irq)
  );

  always #5 clk = ~clk;

  // Registered RX FIFO model: data appears the cycle after the pop.
  always @(posedge clk) if (rx_rd_en) rx_rdata <= cur_rx_byte;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic wr, input int full_cyc,
                              input int empty_cyc, input logic [7:0] rx_byte, input logic exp_ack,
                              input int exp_lat, input int exp_push, input int exp_pop,
                              input int exp_strobe_cyc, input logic [31:0] exp_rdata,
                              input logic [31:0] exp_wdata);
    vec_t v;
    v.name = name; v.addr = addr; v.wdata = wdata; v.strb = strb; v.wr = wr;
    v.full_cyc = full_cyc; v.empty_cyc = empty_cyc; v.rx_byte = rx_byte;
    v.exp_ack = exp_ack; v.exp_lat = exp_lat; v.exp_push = exp_push; v.exp_pop = exp_pop;
    v.exp_strobe_cyc = exp_strobe_cyc; v.exp_rdata = exp_rdata; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  // Drives one request, holds dvalid through the DONE cycle, then compares
  // what was observed against the scoreboard entry.
  task automatic apply(input vec_t v);
    int          lat, pushes, pops, readies, strobe_cyc, budget;
    logic        got;
    logic [31:0] rd, wd;
    vec_t        e;
    sb_q.push_back(v);
    got = 1'b0; lat = -1; pushes = 0; pops = 0; readies = 0; strobe_cyc = -1;
    rd = '0; wd = '0;
    budget = v.exp_ack ? 40 : 8;
    cur_rx_byte = v.rx_byte;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == 0) begin
        daddr = v.addr; dwdata = v.wdata; dstrb = v.strb; dwrite = v.wr; dvalid = 1'b1;
      end
      tx_full  = (c < v.full_cyc);
      rx_empty = (c < v.empty_cyc);
      #1;
      if (tx_wr_en) begin pushes++; wd = {24'd0, tx_wdata}; strobe_cyc = c; end
      if (rx_rd_en) begin pops++; strobe_cyc = c; end
      if (dready) begin
        readies++;
        if (!got) begin got = 1'b1; lat = c; rd = drdata; end
      end
      if (got && c == lat + 1) break;
    end
    @(negedge clk);
    dvalid = 1'b0; tx_full = idle_full; rx_empty = idle_empty;
    e = sb_q.pop_front();
    check({e.name, " ack"}, 32'(got), 32'(e.exp_ack));
    check({e.name, " latency"}, lat, e.exp_lat);
    check({e.name, " ready_pulses"}, readies, e.exp_ack ? 1 : 0);
    check({e.name, " pushes"}, pushes, e.exp_push);
    check({e.name, " pops"}, pops, e.exp_pop);
    check({e.name, " strobe_cycle"}, strobe_cyc, e.exp_strobe_cyc);
    check({e.name, " rdata"}, rd, e.exp_rdata);
    check({e.name, " tx_wdata"}, wd, e.exp_wdata);
  endtask

  initial begin
    //        name            addr        wdata          strb  wr    full empty byte   ack lat push pop scyc  rdata          wdata
    vecs.push_back(mk("tx_push",      B+0,  32'hFFFF_FF41, 4'hF, 1'b1, 0,   BIG, 8'h00, 1, 0,  1, 0,  0,  32'h0,        32'h41));
    vecs.push_back(mk("tx_stall5",    B+0,  32'h42,        4'h1, 1'b1, 5,   BIG, 8'h00, 1, 5,  1, 0,  5,  32'h0,        32'h42));
    vecs.push_back(mk("status_a",     B+8,  32'h0,         4'h0, 1'b0, 0,   BIG, 8'h00, 1, 0,  0, 0, -1,  32'h2,        32'h0));
    vecs.push_back(mk("tx_ovf",       B+0,  32'h43,        4'h1, 1'b1, BIG, BIG, 8'h00, 1, 16, 0, 0, -1,  32'h0,        32'h0));
    vecs.push_back(mk("status_b",     B+8,  32'h0,         4'h0, 1'b0, 0,   BIG, 8'h00, 1, 0,  0, 0, -1,  32'h6,        32'h0));
    vecs.push_back(mk("rx_pop",       B+4,  32'h0,         4'h0, 1'b0, 0,   0,   8'h5A, 1, 1,  0, 1,  0,  32'h5A,       32'h0));
    vecs.push_back(mk("rx_unf",       B+4,  32'h0,         4'h0, 1'b0, 0,   BIG, 8'h00, 1, 0,  0, 0, -1,  32'h0,        32'h0));
    vecs.push_back(mk("status_c",     B+8,  32'h0,         4'h0, 1'b0, 0,   BIG, 8'h00, 1, 0,  0, 0, -1,  32'hE,        32'h0));
    vecs.push_back(mk("w1c_unf",      B+8,  32'h8,         4'h1, 1'b1, 0,   BIG, 8'h00, 1, 0,  0, 0, -1,  32'h0,        32'h0));
    vecs.push_back(mk("status_d",     B+8,  32'h0,         4'h0, 1'b0, 0,   BIG, 8'h00, 1, 0,  0, 0, -1,  32'h6,        32'h0));
    vecs.push_back(mk("ctrl_wr",      B+12, 32'h1,         4'h1, 1'b1, 0,   BIG, 8'h00, 1, 0,  0, 0, -1,  32'h0,        32'h0));
    vecs.push_back(mk("ctrl_rd",      B+12, 32'h0,         4'h0, 1'b0, 0,   BIG, 8'h00, 1, 0,  0, 0, -1,  32'h1,        32'h0));
    vecs.push_back(mk("rx_block",     B+4,  32'h0,         4'h0, 1'b0, 0,   7,   8'hA5, 1, 8,  0, 1,  7,  32'hA5,       32'h0));
    vecs.push_back(mk("ctrl_nostrb",  B+12, 32'hF,         4'hE, 1'b1, 0,   BIG, 8'h00, 1, 0,  0, 0, -1,  32'h0,        32'h0));
    vecs.push_back(mk("ctrl_rd2",     B+12, 32'h0,         4'h0, 1'b0, 0,   BIG, 8'h00, 1, 0,  0, 0, -1,  32'h1,        32'h0));
    vecs.push_back(mk("unmapped_rd",  B+6,  32'h0,         4'h0, 1'b0, 0,   BIG, 8'h00, 1, 0,  0, 0, -1,  32'h0,        32'h0));
    vecs.push_back(mk("rx_write",     B+4,  32'h77,        4'h1, 1'b1, 0,   0,   8'h00, 1, 0,  0, 0, -1,  32'h0,        32'h0));
    vecs.push_back(mk("outwin_rd",    B+20, 32'h0,         4'h0, 1'b0, 0,   0,   8'h00, 0, -1, 0, 0, -1,  32'h0,        32'h0));
    vecs.push_back(mk("outwin_wr",    32'h7000_0000, 32'h55, 4'h1, 1'b1, 0, BIG, 8'h00, 0, -1, 0, 0, -1,  32'h0,        32'h0));
    vecs.push_back(mk("tx_read",      B+0,  32'h0,         4'h0, 1'b0, 0,   BIG, 8'h00, 1, 0,  0, 0, -1,  32'h0,        32'h0));
    vecs.push_back(mk("tx_nostrb",    B+0,  32'h66,        4'h0, 1'b1, 0,   BIG, 8'h00, 1, 0,  0, 0, -1,  32'h0,        32'h0));
    vecs.push_back(mk("w1c_ovf",      B+8,  32'h4,         4'h1, 1'b1, 0,   BIG, 8'h00, 1, 0,  0, 0, -1,  32'h0,        32'h0));
    vecs.push_back(mk("status_e",     B+8,  32'h0,         4'h0, 1'b0, 0,   BIG, 8'h00, 1, 0,  0, 0, -1,  32'h2,        32'h0));
    vecs.push_back(mk("status_full",  B+8,  32'h0,         4'h0, 1'b0, BIG, BIG, 8'h00, 1, 0,  0, 0, -1,  32'h3,        32'h0));

    // Reset with a live TX request: nothing may complete or push.
    reset = 1'b1; daddr = B; dwdata = 32'h11; dstrb = 4'h1; dwrite = 1'b1; dvalid = 1'b1;
    tx_full = 1'b0; rx_empty = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset dready", 32'(dready), 32'd0);
    check("reset tx_wr_en", 32'(tx_wr_en), 32'd0);
    check("reset rx_rd_en", 32'(rx_rd_en), 32'd0);
    check("reset drdata", drdata, 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b0; dvalid = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Interrupt sequence; CTRL currently holds rx_block only.
    #1;
    check("irq_idle", 32'(irq), 32'd0);
    apply(mk("tx_ovf2", B+0, 32'h44, 4'h1, 1'b1, BIG, BIG, 8'h00, 1, 16, 0, 0, -1, 32'h0, 32'h0));
    #1;
    check("irq_masked", 32'(irq), 32'd0);
    apply(mk("ctrl_err_ie", B+12, 32'h8, 4'h1, 1'b1, 0, BIG, 8'h00, 1, 0, 0, 0, -1, 32'h0, 32'h0));
    check("irq_err", 32'(irq), 32'd1);
    apply(mk("w1c_ovf2", B+8, 32'h4, 4'h1, 1'b1, 0, BIG, 8'h00, 1, 0, 0, 0, -1, 32'h0, 32'h0));
    check("irq_clr", 32'(irq), 32'd0);
    idle_empty = 1'b0;
    apply(mk("ctrl_rx_ie", B+12, 32'h4, 4'h1, 1'b1, 0, 0, 8'h00, 1, 0, 0, 0, -1, 32'h0, 32'h0));
    check("irq_rx", 32'(irq), 32'd1);

    // Reset in TX_WAIT: FIFO drains in the reset cycle, yet no completion.
    @(negedge clk);
    daddr = B; dwdata = 32'h99; dstrb = 4'h1; dwrite = 1'b1; dvalid = 1'b1; tx_full = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1; tx_full = 1'b0;
    #1;
    check("abort dready", 32'(dready), 32'd0);
    check("abort tx_wr_en", 32'(tx_wr_en), 32'd0);
    check("abort drdata", drdata, 32'd0);
    @(negedge clk);
    reset = 1'b0; dvalid = 1'b0; idle_empty = 1'b1; rx_empty = 1'b1;
    #1;
    check("abort irq", 32'(irq), 32'd0);
    check("abort dready_after", 32'(dready), 32'd0);
    apply(mk("ctrl_after_rst", B+12, 32'h0, 4'h0, 1'b0, 0, BIG, 8'h00, 1, 0, 0, 0, -1, 32'h0, 32'h0));
    apply(mk("tx_after_rst", B+0, 32'h99, 4'h1, 1'b1, 0, BIG, 8'h00, 1, 0, 1, 0, 0, 32'h0, 32'h99));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
